// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types, field widths and unpack helpers for mem_bus_fabric
package mem_bus_pkg;

   localparam int MAX_REGIONS = 8;
   localparam int SIZE_W      = 5;
   localparam int WAIT_W      = 4;

   // status register bit positions
   localparam int ST_ERR       = 0;
   localparam int ST_ERR_WRITE = 1;
   localparam int ST_OVERRUN   = 2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   function automatic logic [SIZE_W-1:0] unpack_size(
      input logic [MAX_REGIONS*SIZE_W-1:0] sizes,
      input int                            idx
   );
      return sizes[idx*SIZE_W +: SIZE_W];
   endfunction

   function automatic logic [WAIT_W-1:0] unpack_wait(
      input logic [MAX_REGIONS*WAIT_W-1:0] waits,
      input int                            idx
   );
      return waits[idx*WAIT_W +: WAIT_W];
   endfunction

endpackage

// File: rtl/mem_bus_fabric_if.sv
// rtl/mem_bus_fabric_if.sv - CPU data-port bus between the CPU and the fabric
interface mem_bus_fabric_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] din;
   logic              w_en;
   logic              r_en;
   logic [DATA_W-1:0] dout;
   logic              ready;

   modport master (output address, din, w_en, r_en, input dout, ready);
   modport slave  (input address, din, w_en, r_en, output dout, ready);
endinterface

// File: rtl/bus_region_decode.sv
// rtl/bus_region_decode.sv - combinational address decode: region hit, error-block hit, miss, wait count
module bus_region_decode
   import mem_bus_pkg::*;
#(
   parameter int                            ADDR_W           = 16,
   parameter int                            NUM_REGIONS      = 3,
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE      = {16'h2000, 16'h1000, 16'h0000},
   parameter logic [NUM_REGIONS*SIZE_W-1:0] REGION_SIZE_LOG2 = {5'd12, 5'd8, 5'd11},
   parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT      = {4'd2, 4'd0, 4'd0},
   parameter logic [ADDR_W-1:0]             ERR_ADDR         = 16'h10FC
) (
   input  logic [ADDR_W-1:0]      address,
   output logic [NUM_REGIONS-1:0] region_hit,
   output logic                   err_hit,
   output logic                   miss,
   output logic [WAIT_W-1:0]      sel_wait,
   output logic [1:0]             err_offset
);

   localparam logic [MAX_REGIONS*SIZE_W-1:0] SIZES = (MAX_REGIONS*SIZE_W)'(REGION_SIZE_LOG2);
   localparam logic [MAX_REGIONS*WAIT_W-1:0] WAITS = (MAX_REGIONS*WAIT_W)'(REGION_WAIT);

   logic [ADDR_W-1:0] err_diff;
   logic              found;
   logic [SIZE_W-1:0] sz;
   logic [ADDR_W-1:0] base;

   // error block claims its three bytes ahead of every region; otherwise lowest matching index wins
   always_comb begin
      err_diff   = address - ERR_ADDR;
      err_hit    = (err_diff < ADDR_W'(3));
      err_offset = err_diff[1:0];
      region_hit = '0;
      sel_wait   = '0;
      found      = 1'b0;
      sz         = '0;
      base       = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         sz   = unpack_size(SIZES, i);
         base = REGION_BASE[i*ADDR_W +: ADDR_W];
         if (!found && ((address >> sz) == (base >> sz))) begin
            region_hit[i] = 1'b1;
            sel_wait      = unpack_wait(WAITS, i);
            found         = 1'b1;
         end
      end
      if (err_hit) begin
         region_hit = '0;
         sel_wait   = '0;
      end
      miss = !err_hit && !found;
   end

endmodule

// File: rtl/mem_bus_fabric.sv
// rtl/mem_bus_fabric.sv - region decoder with wait states, registered read path and bus-error capture
module mem_bus_fabric
   import mem_bus_pkg::*;
#(
   parameter int                            ADDR_W           = 16,
   parameter int                            DATA_W           = 8,
   parameter int                            NUM_REGIONS      = 3,
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE      = {16'h2000, 16'h1000, 16'h0000},
   parameter logic [NUM_REGIONS*SIZE_W-1:0] REGION_SIZE_LOG2 = {5'd12, 5'd8, 5'd11},
   parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT      = {4'd2, 4'd0, 4'd0},
   parameter logic [ADDR_W-1:0]             ERR_ADDR         = 16'h10FC
) (
   input  logic                          clk,
   input  logic                          rst,
   mem_bus_fabric_if.slave               cpu,
   output logic [NUM_REGIONS-1:0]        region_w_en,
   output logic [NUM_REGIONS-1:0]        region_r_en,
   output logic [ADDR_W-1:0]             region_addr,
   output logic [DATA_W-1:0]             region_din,
   input  logic [NUM_REGIONS*DATA_W-1:0] region_dout,
   output logic                          bus_err_irq
);

   state_t                 state;
   logic [WAIT_W-1:0]      wait_cnt;
   logic [NUM_REGIONS-1:0] sel_hit;
   logic                   sel_wr;
   logic                   ready_q;
   logic [DATA_W-1:0]      dout_q;

   logic [NUM_REGIONS-1:0] region_hit;
   logic                   err_hit;
   logic                   miss;
   logic [WAIT_W-1:0]      sel_wait;
   logic [1:0]             err_offset;

   logic [2:0]             status;
   logic [2:0]             status_n;
   logic [ADDR_W-1:0]      fault_addr;
   logic [ADDR_W-1:0]      fault_n;
   logic [15:0]            fault16;
   logic                   req;
   logic                   both;
   logic                   new_err;
   logic                   local_acc;
   logic                   clr;
   logic [DATA_W-1:0]      local_rd;
   logic [DATA_W-1:0]      rd_sel;

   bus_region_decode #(
      .ADDR_W           (ADDR_W),
      .NUM_REGIONS      (NUM_REGIONS),
      .REGION_BASE      (REGION_BASE),
      .REGION_SIZE_LOG2 (REGION_SIZE_LOG2),
      .REGION_WAIT      (REGION_WAIT),
      .ERR_ADDR         (ERR_ADDR)
   ) u_decode (
      .address    (cpu.address),
      .region_hit (region_hit),
      .err_hit    (err_hit),
      .miss       (miss),
      .sel_wait   (sel_wait),
      .err_offset (err_offset)
   );

   assign cpu.ready   = ready_q;
   assign cpu.dout    = dout_q;
   assign bus_err_irq = status[ST_ERR];

   // request classification and next error-register state; a clear lands before a same-cycle capture
   always_comb begin
      req       = (state == S_IDLE) && (cpu.w_en || cpu.r_en);
      both      = cpu.w_en && cpu.r_en;
      new_err   = req && (miss || both);
      local_acc = req && err_hit && !both;
      clr       = local_acc && cpu.w_en && (err_offset == 2'd0) && cpu.din[0];
      status_n  = clr ? 3'b000 : status;
      fault_n   = fault_addr;
      if (new_err) begin
         if (!status_n[ST_ERR]) begin
            status_n[ST_ERR]       = 1'b1;
            status_n[ST_ERR_WRITE] = cpu.w_en && !cpu.r_en;
            fault_n                = cpu.address;
         end else begin
            status_n[ST_OVERRUN] = 1'b1;
         end
      end
   end

   // read data sources: local error-block registers and the selected target slice
   always_comb begin
      fault16 = 16'(fault_addr);
      case (err_offset)
         2'd0:    local_rd = DATA_W'(status);
         2'd1:    local_rd = DATA_W'(fault16[7:0]);
         2'd2:    local_rd = DATA_W'(fault16[15:8]);
         default: local_rd = '0;
      endcase
      rd_sel = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (sel_hit[i]) begin
            rd_sel = rd_sel | region_dout[i*DATA_W +: DATA_W];
         end
      end
   end

   // error status and fault address registers
   always_ff @(posedge clk) begin
      if (rst) begin
         status     <= '0;
         fault_addr <= '0;
      end else begin
         status     <= status_n;
         fault_addr <= fault_n;
      end
   end

   // transaction FSM with registered strobes, ready and read data
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         wait_cnt    <= '0;
         sel_hit     <= '0;
         sel_wr      <= 1'b0;
         ready_q     <= 1'b0;
         dout_q      <= '0;
         region_w_en <= '0;
         region_r_en <= '0;
         region_addr <= '0;
         region_din  <= '0;
      end else begin
         region_w_en <= '0;
         region_r_en <= '0;
         ready_q     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  region_addr <= cpu.address;
                  region_din  <= cpu.din;
                  sel_wr      <= cpu.w_en;
                  sel_hit     <= region_hit;
                  if (new_err) begin
                     state   <= S_RESP;
                     ready_q <= 1'b1;
                     dout_q  <= '0;
                  end else if (local_acc) begin
                     state   <= S_RESP;
                     ready_q <= 1'b1;
                     dout_q  <= cpu.w_en ? '0 : local_rd;
                  end else if (sel_wait == '0) begin
                     state       <= S_ACCESS;
                     region_w_en <= region_hit & {NUM_REGIONS{cpu.w_en}};
                     region_r_en <= region_hit & {NUM_REGIONS{cpu.r_en}};
                  end else begin
                     state    <= S_WAIT;
                     wait_cnt <= sel_wait;
                  end
               end
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt - WAIT_W'(1);
               if (wait_cnt == WAIT_W'(1)) begin
                  state       <= S_ACCESS;
                  region_w_en <= sel_hit & {NUM_REGIONS{sel_wr}};
                  region_r_en <= sel_hit & {NUM_REGIONS{!sel_wr}};
               end
            end
            S_ACCESS: begin
               state   <= S_RESP;
               ready_q <= 1'b1;
               dout_q  <= sel_wr ? '0 : rd_sel;
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_fabric.sv
// tb/tb_mem_bus_fabric.sv - directed self-checking bench for mem_bus_fabric
module tb_mem_bus_fabric;

   logic        clk;
   logic        rst;
   logic [2:0]  region_w_en;
   logic [2:0]  region_r_en;
   logic [15:0] region_addr;
   logic [7:0]  region_din;
   logic [23:0] region_dout;
   logic        bus_err_irq;

   int          checks;
   int          errors;

   int          lat;
   logic [7:0]  rd;
   int          npulse;
   int          s_cycle;
   logic [2:0]  s_w;
   logic [2:0]  s_r;
   logic [15:0] s_addr;
   logic [7:0]  s_din;
   logic        irq_first;
   logic        irq_ready;
   int          nready;

   mem_bus_fabric_if #(.ADDR_W(16), .DATA_W(8)) bus ();

   mem_bus_fabric dut (
      .clk         (clk),
      .rst         (rst),
      .cpu         (bus),
      .region_w_en (region_w_en),
      .region_r_en (region_r_en),
      .region_addr (region_addr),
      .region_din  (region_din),
      .region_dout (region_dout),
      .bus_err_irq (bus_err_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic xact(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
      @(posedge clk);
      #1;
      bus.address = a;
      bus.din     = d;
      bus.w_en    = w;
      bus.r_en    = r;
      lat = 0; rd = 8'hxx; npulse = 0; s_cycle = 0;
      s_w = '0; s_r = '0; s_addr = '0; s_din = '0;
      irq_first = 1'bx; irq_ready = 1'bx;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) irq_first = bus_err_irq;
         if ((region_w_en | region_r_en) != 3'b000) begin
            npulse++;
            s_cycle = k;
            s_w     = region_w_en;
            s_r     = region_r_en;
            s_addr  = region_addr;
            s_din   = region_din;
         end
         if (bus.ready) begin
            lat       = k;
            rd        = bus.dout;
            irq_ready = bus_err_irq;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.w_en = 1'b0;
      bus.r_en = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.address = '0; bus.din = '0; bus.w_en = 1'b0; bus.r_en = 1'b0;
      region_dout = {8'h77, 8'h5A, 8'hA5};
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(bus.ready), 32'h0);
      chk("rst_dout", 32'(bus.dout), 32'h0);
      chk("rst_strobes", 32'({region_w_en, region_r_en}), 32'h0);
      chk("rst_addr", 32'(region_addr), 32'h0);
      chk("rst_din", 32'(region_din), 32'h0);
      chk("rst_irq", 32'(bus_err_irq), 32'h0);

      // RAM read, no wait states
      xact(16'h0010, 8'h00, 1'b0, 1'b1);
      chk("ram_rd_lat", 32'(lat), 32'd3);
      chk("ram_rd_dout", 32'(rd), 32'hA5);
      chk("ram_rd_pulses", 32'(npulse), 32'd1);
      chk("ram_rd_strobe", 32'({s_w, s_r}), 32'h01);
      chk("ram_rd_addr", 32'(s_addr), 32'h0010);

      // VRAM write, two wait states
      xact(16'h2005, 8'h3C, 1'b1, 1'b0);
      chk("vram_wr_lat", 32'(lat), 32'd5);
      chk("vram_wr_cycle", 32'(s_cycle), 32'd4);
      chk("vram_wr_strobe", 32'({s_w, s_r}), 32'h20);
      chk("vram_wr_addr", 32'(s_addr), 32'h2005);
      chk("vram_wr_din", 32'(s_din), 32'h3C);
      chk("vram_wr_dout", 32'(rd), 32'h00);

      // IO byte just past the error block belongs to region 1
      xact(16'h10FF, 8'h00, 1'b0, 1'b1);
      chk("io_rd_lat", 32'(lat), 32'd3);
      chk("io_rd_dout", 32'(rd), 32'h5A);
      chk("io_rd_strobe", 32'({s_w, s_r}), 32'h02);

      // top byte of RAM
      xact(16'h07FF, 8'h00, 1'b0, 1'b1);
      chk("ram_top_lat", 32'(lat), 32'd3);
      chk("ram_top_strobe", 32'({s_w, s_r}), 32'h01);

      // unmapped read
      xact(16'h0900, 8'h00, 1'b0, 1'b1);
      chk("unm_rd_pulses", 32'(npulse), 32'd0);
      chk("unm_rd_lat", 32'(lat), 32'd2);
      chk("unm_rd_dout", 32'(rd), 32'h00);
      chk("unm_irq_before", 32'(irq_first), 32'h0);
      chk("unm_irq_ready", 32'(irq_ready), 32'h1);
      xact(16'h10FD, 8'h00, 1'b0, 1'b1);
      chk("fault_lo_lat", 32'(lat), 32'd2);
      chk("fault_lo", 32'(rd), 32'h00);
      chk("fault_lo_pulses", 32'(npulse), 32'd0);
      xact(16'h10FE, 8'h00, 1'b0, 1'b1);
      chk("fault_hi", 32'(rd), 32'h09);
      xact(16'h10FC, 8'h00, 1'b0, 1'b1);
      chk("status_err", 32'(rd), 32'h01);

      // second error while err is set: overrun only
      xact(16'h4000, 8'hEE, 1'b1, 1'b0);
      chk("unm_wr_lat", 32'(lat), 32'd2);
      chk("unm_wr_pulses", 32'(npulse), 32'd0);
      xact(16'h10FC, 8'h00, 1'b0, 1'b1);
      chk("status_ovr", 32'(rd), 32'h05);
      xact(16'h10FD, 8'h00, 1'b0, 1'b1);
      chk("ovr_fault_lo", 32'(rd), 32'h00);
      xact(16'h10FE, 8'h00, 1'b0, 1'b1);
      chk("ovr_fault_hi", 32'(rd), 32'h09);

      // clear
      xact(16'h10FC, 8'h01, 1'b1, 1'b0);
      chk("clr_lat", 32'(lat), 32'd2);
      chk("clr_irq", 32'(bus_err_irq), 32'h0);
      xact(16'h10FC, 8'h00, 1'b0, 1'b1);
      chk("clr_status", 32'(rd), 32'h00);

      // simultaneous read and write
      xact(16'h1002, 8'h00, 1'b1, 1'b1);
      chk("both_pulses", 32'(npulse), 32'd0);
      chk("both_lat", 32'(lat), 32'd2);
      chk("both_dout", 32'(rd), 32'h00);
      chk("both_irq", 32'(irq_ready), 32'h1);
      xact(16'h10FC, 8'h00, 1'b0, 1'b1);
      chk("both_status", 32'(rd), 32'h01);
      xact(16'h10FD, 8'h00, 1'b0, 1'b1);
      chk("both_fault_lo", 32'(rd), 32'h02);
      xact(16'h10FE, 8'h00, 1'b0, 1'b1);
      chk("both_fault_hi", 32'(rd), 32'h10);
      xact(16'h10FC, 8'h01, 1'b1, 1'b0);

      // reset while a VRAM write sits in WAIT
      @(posedge clk);
      #1;
      bus.address = 16'h2010; bus.din = 8'h55; bus.w_en = 1'b1; bus.r_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.w_en = 1'b0;
      npulse = 0;
      nready = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (region_w_en != 3'b000) npulse++;
         if (bus.ready) nready++;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (region_w_en != 3'b000) npulse++;
         if (bus.ready) nready++;
      end
      chk("rstw_no_strobe", 32'(npulse), 32'd0);
      chk("rstw_no_ready", 32'(nready), 32'd0);
      chk("rstw_addr", 32'(region_addr), 32'h0);
      xact(16'h0010, 8'h00, 1'b0, 1'b1);
      chk("post_rst_lat", 32'(lat), 32'd3);
      chk("post_rst_dout", 32'(rd), 32'hA5);
      chk("post_rst_pulses", 32'(npulse), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_bus_fabric.md
# mem_bus_fabric

Parametrised successor to the fixed RAM/IO address decoder that sits between the CPU data port and all memory-mapped targets. It has N configurable address regions, per-region wait states, a registered read-data path and a `ready` handshake back to the CPU. It also captures illegal accesses in a bus-error register that raises an interrupt line for the PIC. RAM, the IO peripheral cluster and VRAM each attach as one region.

## Interface
Parameters:
- `ADDR_W`, 16: CPU address width (≤16).
- `DATA_W`, 8: data width.
- `NUM_REGIONS`, 3: number of target regions (1–8).
- `REGION_BASE`, {16'h2000,16'h1000,16'h0000}: packed `NUM_REGIONS*ADDR_W`; region i base in slice i.
- `REGION_SIZE_LOG2`, {5'd12,5'd8,5'd11}: packed 5 bits per region; size = 2^n, base aligned to size.
- `REGION_WAIT`, {4'd2,4'd0,4'd0}: packed 4 bits per region; extra wait cycles before the strobe.
- `ERR_ADDR`, 16'h10FC: bus-error register block (3 bytes), claimed ahead of all regions.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `address` in `ADDR_W`: CPU address, held until `ready`.
- `din` in `DATA_W`: CPU write data, held until `ready`.
- `w_en`, `r_en` in 1: CPU request, held until `ready`.
- `dout` out `DATA_W`: registered read data, valid while `ready`=1.
- `ready` out 1: one-cycle completion pulse.
- `region_w_en`, `region_r_en` out `NUM_REGIONS`: one-hot single-cycle strobes.
- `region_addr`, `region_din` out `ADDR_W`/`DATA_W`: registered copies of the request.
- `region_dout` in `NUM_REGIONS*DATA_W`: target read data, valid 1 cycle after `region_r_en`.
- `bus_err_irq` out 1: level, equals sticky error bit.

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE, no request: nothing happens.
- IDLE, `w_en|r_en` set: latch address, data and direction, then decode.
  - Decode priority: ERR_ADDR..+2 first, then the lowest-index matching region. Region i matches when `address>>size_i == base_i>>size_i`.
  - Wait count 0: go to ACCESS.
  - Wait count nonzero: load the counter and go to WAIT.
  - Unmapped address, or `w_en&r_en` both set: record the error and go straight to RESP with `dout`=0 and no strobe.
- WAIT: decrement the counter each cycle; at 0, go to ACCESS.
- ACCESS: assert the selected strobe for exactly 1 cycle, then go to RESP.
- RESP:
  - `ready`=1.
  - On a read, `dout` is captured from the selected `region_dout` slice; on a write, `dout`=0.
  - Request inputs are ignored this cycle; return to IDLE.
- Error registers (local, no strobe, same 2-cycle latency):
  - +0 status: bit0 err, bit1 err_write, bit2 overrun. Writing 1 to bit0 clears bits 0–2.
  - +1 fault address low byte; +2 fault address high byte. Both are read-only.
- Error capture:
  - On a new error with err=0: set err, store the address and direction.
  - On a new error with err=1: set overrun only; the stored address is preserved.
  - An error in the same cycle as a clear of err: the clear applies first, then the new error is captured.

## Timing
- Reset values: state IDLE, `ready`=0, `dout`=0, all strobes 0, `region_addr`/`region_din` 0, status 0, fault address 0, `bus_err_irq`=0.
- Latency from request to `ready`:
  - wait 0: 3 cycles (IDLE→ACCESS→RESP).
  - wait w: 3+w cycles.
  - error or local register access: 2 cycles.
- `region_addr`/`region_din` are stable from ACCESS through RESP.
- CPU requirement: deassert the request, or present the next one, in the cycle after `ready`. A request still held in IDLE is treated as a new access.
- Reset mid-transaction: all strobes and `ready` drop at the reset edge. The in-flight access is abandoned and not retried.
- Overlapping regions are legal; the lower index wins.
- `bus_err_irq` rises the cycle after the faulting request is decoded.

## Structure
- Package `mem_bus_pkg`: state encoding, status bit indices, field widths (5-bit size, 4-bit wait), unpack helper functions.
- Sub-module `bus_region_decode`: combinational; produces the one-hot region hit, the ERR hit, the miss flag and the selected wait count. The FSM, error registers and read mux stay in the top level.

## Test plan
- Read 0x0010 (RAM, wait 0), `region_dout[0]`=8'hA5 → `region_r_en[0]` pulses once; `ready` in cycle 3; `dout`=8'hA5.
- Write 8'h3C to 0x2005 (VRAM, wait 2) → `region_w_en[2]` in cycle 4 with `region_addr`=0x2005 and `region_din`=8'h3C; `ready` in cycle 5.
- Read 0x0900 (unmapped) → no strobe; `ready` in cycle 2 with `dout`=0; `bus_err_irq`=1; reads of 0x10FD/0x10FE return 8'h00/8'h09.
- Second unmapped write to 0x4000 while err=1 → status reads 8'h05 and the fault address stays 0x0900; writing 8'h01 to 0x10FC → status 0, irq 0.
- `w_en`=`r_en`=1 at 0x1002 → no strobe; err=1, err_write=0.
- Assert `rst` during WAIT on a VRAM write → `region_w_en` never asserts; `ready`=0; the next read of 0x0010 completes normally in 3 cycles.
